// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory port, stack pointer and registered MEM/WB outputs.
// 32-bit PC push/pop runs as two 16-bit stack accesses with a one-cycle stall.
//
// state   | meaning
// IDLE    | single-cycle op, or first half of a PC push/pop (stall high)
// PUSHPC2 | writing PC low half at sp-1
// POPPC2  | reading PC high half at sp+2
module mem_stage_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int SP_RESET = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ALU_result_mem,
    input  logic [15:0]       Rs_data_mem,
    input  logic [2:0]        Rd_mem,
    input  logic              memRead_mem,
    input  logic              memWrite_mem,
    input  logic              regWrite_mem,
    input  logic              push_mem,
    input  logic              pop_mem,
    input  logic              pushPc_mem,
    input  logic              popPc_mem,
    input  logic              pushCCR_mem,
    input  logic              popCCR_mem,
    input  logic [31:0]       pcBeforeInterrupt_mem,
    input  logic [3:0]        ccr_in,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [15:0]       dmem_rdata,
    output logic              stall,
    output logic [15:0]       wb_data,
    output logic [2:0]        wb_rd,
    output logic              wb_regWrite,
    output logic [31:0]       pc_restore,
    output logic              pc_restore_valid,
    output logic [3:0]        ccr_restore,
    output logic              ccr_restore_valid,
    output logic [ADDR_W-1:0] sp
);

    typedef enum logic [1:0] {IDLE, PUSHPC2, POPPC2} state_t;

    localparam logic [ADDR_W-1:0] SP_INIT = SP_RESET[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ONE     = 1;
    localparam logic [ADDR_W-1:0] TWO     = 2;

    state_t            state;
    logic [ADDR_W-1:0] sp_q;
    logic [15:0]       pc_lo_q;

    logic is_pushpc, is_poppc, is_pushccr, is_popccr, is_push, is_pop, is_memw, is_memr;
    logic [ADDR_W-1:0] addr_c;
    logic [15:0]       wdata_c;
    logic              we_c, re_c, stall_c, wb_from_mem_c;

    assign sp = sp_q;

    // One operation per instruction; lower-priority flags are dropped.
    always_comb begin
        is_pushpc  = 1'b0;
        is_poppc   = 1'b0;
        is_pushccr = 1'b0;
        is_popccr  = 1'b0;
        is_push    = 1'b0;
        is_pop     = 1'b0;
        is_memw    = 1'b0;
        is_memr    = 1'b0;
        if (pushPc_mem)        is_pushpc  = 1'b1;
        else if (popPc_mem)    is_poppc   = 1'b1;
        else if (pushCCR_mem)  is_pushccr = 1'b1;
        else if (popCCR_mem)   is_popccr  = 1'b1;
        else if (push_mem)     is_push    = 1'b1;
        else if (pop_mem)      is_pop     = 1'b1;
        else if (memWrite_mem) is_memw    = 1'b1;
        else if (memRead_mem)  is_memr    = 1'b1;
    end

    always_comb begin
        addr_c        = ALU_result_mem[ADDR_W-1:0];
        wdata_c       = Rs_data_mem;
        we_c          = 1'b0;
        re_c          = 1'b0;
        stall_c       = 1'b0;
        wb_from_mem_c = 1'b0;
        case (state)
            IDLE: begin
                if (is_pushpc) begin
                    addr_c  = sp_q;
                    wdata_c = pcBeforeInterrupt_mem[31:16];
                    we_c    = 1'b1;
                    stall_c = 1'b1;
                end else if (is_poppc) begin
                    addr_c  = sp_q + ONE;
                    re_c    = 1'b1;
                    stall_c = 1'b1;
                end else if (is_pushccr) begin
                    addr_c  = sp_q;
                    wdata_c = {12'b0, ccr_in};
                    we_c    = 1'b1;
                end else if (is_popccr) begin
                    addr_c  = sp_q + ONE;
                    re_c    = 1'b1;
                end else if (is_push) begin
                    addr_c  = sp_q;
                    we_c    = 1'b1;
                end else if (is_pop) begin
                    addr_c        = sp_q + ONE;
                    re_c          = 1'b1;
                    wb_from_mem_c = 1'b1;
                end else if (is_memw) begin
                    we_c = 1'b1;
                end else if (is_memr) begin
                    re_c          = 1'b1;
                    wb_from_mem_c = 1'b1;
                end
            end
            PUSHPC2: begin
                addr_c  = sp_q - ONE;
                wdata_c = pcBeforeInterrupt_mem[15:0];
                we_c    = 1'b1;
            end
            POPPC2: begin
                addr_c = sp_q + TWO;
                re_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so an aborted sequence cannot write.
    assign dmem_addr  = addr_c;
    assign dmem_wdata = wdata_c;
    assign dmem_we    = we_c & rst_n;
    assign dmem_re    = re_c & rst_n;
    assign stall      = stall_c & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            sp_q              <= SP_INIT;
            pc_lo_q           <= '0;
            wb_data           <= '0;
            wb_rd             <= '0;
            wb_regWrite       <= 1'b0;
            pc_restore        <= '0;
            pc_restore_valid  <= 1'b0;
            ccr_restore       <= '0;
            ccr_restore_valid <= 1'b0;
        end else begin
            pc_restore_valid  <= 1'b0;
            ccr_restore_valid <= 1'b0;
            wb_rd             <= Rd_mem;
            wb_regWrite       <= regWrite_mem & ~stall_c;
            wb_data           <= wb_from_mem_c ? dmem_rdata : ALU_result_mem;
            case (state)
                IDLE: begin
                    if (is_pushpc) begin
                        state <= PUSHPC2;
                    end else if (is_poppc) begin
                        pc_lo_q <= dmem_rdata;
                        state   <= POPPC2;
                    end else if (is_pushccr || is_push) begin
                        sp_q <= sp_q - ONE;
                    end else if (is_popccr || is_pop) begin
                        sp_q <= sp_q + ONE;
                    end
                    if (is_popccr) begin
                        ccr_restore       <= dmem_rdata[3:0];
                        ccr_restore_valid <= 1'b1;
                    end
                end
                PUSHPC2: begin
                    sp_q  <= sp_q - TWO;
                    state <= IDLE;
                end
                POPPC2: begin
                    pc_restore       <= {dmem_rdata, pc_lo_q};
                    pc_restore_valid <= 1'b1;
                    sp_q             <= sp_q + TWO;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: two instances (default SP and SP_RESET=0), each with
// a behavioural single-port memory.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ALU_result_mem, Rs_data_mem;
    logic [2:0]  Rd_mem;
    logic        memRead_mem, memWrite_mem, regWrite_mem, push_mem, pop_mem;
    logic        pushPc_mem, popPc_mem, pushCCR_mem, popCCR_mem;
    logic [31:0] pcBeforeInterrupt_mem;
    logic [3:0]  ccr_in;

    logic [10:0] dmem_addr1, sp1, dmem_addr2, sp2;
    logic [15:0] dmem_wdata1, dmem_rdata1, wb_data1, dmem_wdata2, dmem_rdata2, wb_data2;
    logic        dmem_we1, dmem_re1, stall1, wb_regWrite1, pc_restore_valid1, ccr_restore_valid1;
    logic        dmem_we2, dmem_re2, stall2, wb_regWrite2, pc_restore_valid2, ccr_restore_valid2;
    logic [2:0]  wb_rd1, wb_rd2;
    logic [31:0] pc_restore1, pc_restore2;
    logic [3:0]  ccr_restore1, ccr_restore2;

    logic [15:0] mem1 [0:2047];
    logic [15:0] mem2 [0:2047];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (dmem_we1) mem1[dmem_addr1] <= dmem_wdata1;
    always @(posedge clk) if (dmem_we2) mem2[dmem_addr2] <= dmem_wdata2;
    assign dmem_rdata1 = mem1[dmem_addr1];
    assign dmem_rdata2 = mem2[dmem_addr2];

    mem_stage_ctrl dut1 (
        .clk(clk), .rst_n(rst_n), .ALU_result_mem(ALU_result_mem), .Rs_data_mem(Rs_data_mem),
        .Rd_mem(Rd_mem), .memRead_mem(memRead_mem), .memWrite_mem(memWrite_mem),
        .regWrite_mem(regWrite_mem), .push_mem(push_mem), .pop_mem(pop_mem),
        .pushPc_mem(pushPc_mem), .popPc_mem(popPc_mem), .pushCCR_mem(pushCCR_mem),
        .popCCR_mem(popCCR_mem), .pcBeforeInterrupt_mem(pcBeforeInterrupt_mem), .ccr_in(ccr_in),
        .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1), .dmem_we(dmem_we1), .dmem_re(dmem_re1),
        .dmem_rdata(dmem_rdata1), .stall(stall1), .wb_data(wb_data1), .wb_rd(wb_rd1),
        .wb_regWrite(wb_regWrite1), .pc_restore(pc_restore1), .pc_restore_valid(pc_restore_valid1),
        .ccr_restore(ccr_restore1), .ccr_restore_valid(ccr_restore_valid1), .sp(sp1)
    );

    mem_stage_ctrl #(.ADDR_W(11), .SP_RESET(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .ALU_result_mem(ALU_result_mem), .Rs_data_mem(Rs_data_mem),
        .Rd_mem(Rd_mem), .memRead_mem(memRead_mem), .memWrite_mem(memWrite_mem),
        .regWrite_mem(regWrite_mem), .push_mem(push_mem), .pop_mem(pop_mem),
        .pushPc_mem(pushPc_mem), .popPc_mem(popPc_mem), .pushCCR_mem(pushCCR_mem),
        .popCCR_mem(popCCR_mem), .pcBeforeInterrupt_mem(pcBeforeInterrupt_mem), .ccr_in(ccr_in),
        .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2), .dmem_we(dmem_we2), .dmem_re(dmem_re2),
        .dmem_rdata(dmem_rdata2), .stall(stall2), .wb_data(wb_data2), .wb_rd(wb_rd2),
        .wb_regWrite(wb_regWrite2), .pc_restore(pc_restore2), .pc_restore_valid(pc_restore_valid2),
        .ccr_restore(ccr_restore2), .ccr_restore_valid(ccr_restore_valid2), .sp(sp2)
    );

    task automatic clear_inputs();
        ALU_result_mem = 16'h0; Rs_data_mem = 16'h0; Rd_mem = 3'd0;
        memRead_mem = 0; memWrite_mem = 0; regWrite_mem = 0; push_mem = 0; pop_mem = 0;
        pushPc_mem = 0; popPc_mem = 0; pushCCR_mem = 0; popCCR_mem = 0;
        pcBeforeInterrupt_mem = 32'h0; ccr_in = 4'h0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_dut();
        n_total++; if (sp1 !== 11'h7FF) $display("FAIL rst_sp: got %h want 7ff", sp1); else n_pass++;
        n_total++; if ({wb_data1, wb_rd1, wb_regWrite1, pc_restore1, pc_restore_valid1, ccr_restore1, ccr_restore_valid1} !== 57'h0)
            $display("FAIL rst_outputs: wb_data %h wb_rd %h wbw %b pc %h pcv %b ccr %h ccrv %b, want all 0",
                     wb_data1, wb_rd1, wb_regWrite1, pc_restore1, pc_restore_valid1, ccr_restore1, ccr_restore_valid1);
        else n_pass++;
        // Start a PC push, then pull reset during its second cycle.
        pushPc_mem = 1; pcBeforeInterrupt_mem = 32'h1234_5678;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (sp1 !== 11'h7FF) $display("FAIL abort_sp: got %h want 7ff", sp1); else n_pass++;
        n_total++; if ({stall1, dmem_we1, dmem_re1} !== 3'b000)
            $display("FAIL abort_strobes: stall/we/re %b want 000", {stall1, dmem_we1, dmem_re1});
        else n_pass++;
        step();
        n_total++; if (mem1[11'h7FE] === 16'h5678) $display("FAIL abort_no_write: mem[7fe] %h was written", mem1[11'h7FE]); else n_pass++;
        n_total++; if (pc_restore_valid1 !== 1'b0) $display("FAIL abort_pcv: got %b want 0", pc_restore_valid1); else n_pass++;
        clear_inputs();
        rst_n = 1'b1;
        step();
        push_mem = 1; Rs_data_mem = 16'h1111;
        #1;
        n_total++; if (dmem_addr1 !== 11'h7FF || dmem_we1 !== 1'b1 || stall1 !== 1'b0)
            $display("FAIL first_push: addr %h we %b stall %b want 7ff 1 0", dmem_addr1, dmem_we1, stall1);
        else n_pass++;
        step();
        clear_inputs();
        n_total++; if (mem1[11'h7FF] !== 16'h1111) $display("FAIL first_push_mem: got %h want 1111", mem1[11'h7FF]); else n_pass++;
    endtask

    task automatic test_push_pop();
        reset_dut();
        push_mem = 1; Rs_data_mem = 16'hBEEF;
        #1;
        n_total++; if (dmem_addr1 !== 11'h7FF || dmem_we1 !== 1 || dmem_re1 !== 0 || dmem_wdata1 !== 16'hBEEF)
            $display("FAIL push_port: addr %h we %b re %b wdata %h want 7ff 1 0 beef", dmem_addr1, dmem_we1, dmem_re1, dmem_wdata1);
        else n_pass++;
        step();
        n_total++; if (sp1 !== 11'h7FE) $display("FAIL push_sp: got %h want 7fe", sp1); else n_pass++;
        clear_inputs();
        pop_mem = 1; Rd_mem = 3'd3; regWrite_mem = 1; ALU_result_mem = 16'h0123;
        #1;
        n_total++; if (dmem_addr1 !== 11'h7FF || dmem_re1 !== 1 || dmem_we1 !== 0)
            $display("FAIL pop_port: addr %h re %b we %b want 7ff 1 0", dmem_addr1, dmem_re1, dmem_we1);
        else n_pass++;
        step();
        n_total++; if (wb_data1 !== 16'hBEEF || wb_rd1 !== 3'd3 || wb_regWrite1 !== 1)
            $display("FAIL pop_wb: data %h rd %0d wbw %b want beef 3 1", wb_data1, wb_rd1, wb_regWrite1);
        else n_pass++;
        n_total++; if (sp1 !== 11'h7FF) $display("FAIL pop_sp: got %h want 7ff", sp1); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_pushpc_poppc();
        reset_dut();
        pushPc_mem = 1; pcBeforeInterrupt_mem = 32'h1234_5678; regWrite_mem = 1; Rd_mem = 3'd6;
        #1;
        n_total++; if (stall1 !== 1 || dmem_addr1 !== 11'h7FF || dmem_wdata1 !== 16'h1234 || dmem_we1 !== 1)
            $display("FAIL pushpc_c1: stall %b addr %h wdata %h we %b want 1 7ff 1234 1", stall1, dmem_addr1, dmem_wdata1, dmem_we1);
        else n_pass++;
        step();
        n_total++; if (wb_regWrite1 !== 0 || sp1 !== 11'h7FF)
            $display("FAIL pushpc_e1: wbw %b sp %h want 0 7ff", wb_regWrite1, sp1);
        else n_pass++;
        #1;
        n_total++; if (stall1 !== 0 || dmem_addr1 !== 11'h7FE || dmem_wdata1 !== 16'h5678 || dmem_we1 !== 1)
            $display("FAIL pushpc_c2: stall %b addr %h wdata %h we %b want 0 7fe 5678 1", stall1, dmem_addr1, dmem_wdata1, dmem_we1);
        else n_pass++;
        step();
        n_total++; if (sp1 !== 11'h7FD || wb_regWrite1 !== 1 || mem1[11'h7FF] !== 16'h1234 || mem1[11'h7FE] !== 16'h5678)
            $display("FAIL pushpc_e2: sp %h wbw %b m7ff %h m7fe %h want 7fd 1 1234 5678", sp1, wb_regWrite1, mem1[11'h7FF], mem1[11'h7FE]);
        else n_pass++;
        clear_inputs();
        step();
        n_total++; if (wb_regWrite1 !== 0) $display("FAIL pushpc_single_retire: wbw %b want 0", wb_regWrite1); else n_pass++;
        popPc_mem = 1;
        #1;
        n_total++; if (stall1 !== 1 || dmem_addr1 !== 11'h7FE || dmem_re1 !== 1 || dmem_we1 !== 0)
            $display("FAIL poppc_c1: stall %b addr %h re %b we %b want 1 7fe 1 0", stall1, dmem_addr1, dmem_re1, dmem_we1);
        else n_pass++;
        step();
        n_total++; if (pc_restore_valid1 !== 0) $display("FAIL poppc_early_valid: got %b want 0", pc_restore_valid1); else n_pass++;
        #1;
        n_total++; if (stall1 !== 0 || dmem_addr1 !== 11'h7FF || dmem_re1 !== 1)
            $display("FAIL poppc_c2: stall %b addr %h re %b want 0 7ff 1", stall1, dmem_addr1, dmem_re1);
        else n_pass++;
        step();
        n_total++; if (pc_restore1 !== 32'h1234_5678 || pc_restore_valid1 !== 1 || sp1 !== 11'h7FF)
            $display("FAIL poppc_e2: pc %h valid %b sp %h want 12345678 1 7ff", pc_restore1, pc_restore_valid1, sp1);
        else n_pass++;
        clear_inputs();
        step();
        n_total++; if (pc_restore_valid1 !== 0 || pc_restore1 !== 32'h1234_5678)
            $display("FAIL poppc_pulse: valid %b pc %h want 0 12345678", pc_restore_valid1, pc_restore1);
        else n_pass++;
    endtask

    task automatic test_ccr();
        reset_dut();
        pushCCR_mem = 1; ccr_in = 4'hA; Rs_data_mem = 16'hFFFF;
        #1;
        n_total++; if (dmem_addr1 !== 11'h7FF || dmem_wdata1 !== 16'h000A || dmem_we1 !== 1)
            $display("FAIL pushccr_port: addr %h wdata %h we %b want 7ff 000a 1", dmem_addr1, dmem_wdata1, dmem_we1);
        else n_pass++;
        step();
        n_total++; if (sp1 !== 11'h7FE) $display("FAIL pushccr_sp: got %h want 7fe", sp1); else n_pass++;
        clear_inputs();
        popCCR_mem = 1;
        step();
        n_total++; if (ccr_restore1 !== 4'hA || ccr_restore_valid1 !== 1 || sp1 !== 11'h7FF)
            $display("FAIL popccr: ccr %h valid %b sp %h want a 1 7ff", ccr_restore1, ccr_restore_valid1, sp1);
        else n_pass++;
        clear_inputs();
        step();
        n_total++; if (ccr_restore_valid1 !== 0 || ccr_restore1 !== 4'hA)
            $display("FAIL popccr_pulse: valid %b ccr %h want 0 a", ccr_restore_valid1, ccr_restore1);
        else n_pass++;
    endtask

    task automatic test_mem_rw();
        reset_dut();
        memWrite_mem = 1; ALU_result_mem = 16'h0010; Rs_data_mem = 16'h5A5A;
        #1;
        n_total++; if (dmem_addr1 !== 11'h010 || dmem_we1 !== 1 || dmem_re1 !== 0)
            $display("FAIL memw_port: addr %h we %b re %b want 010 1 0", dmem_addr1, dmem_we1, dmem_re1);
        else n_pass++;
        step();
        clear_inputs();
        memRead_mem = 1; ALU_result_mem = 16'h0010; regWrite_mem = 1; Rd_mem = 3'd5;
        #1;
        n_total++; if (dmem_re1 !== 1 || dmem_we1 !== 0) $display("FAIL memr_port: re %b we %b want 1 0", dmem_re1, dmem_we1); else n_pass++;
        step();
        n_total++; if (wb_data1 !== 16'h5A5A || wb_rd1 !== 3'd5 || wb_regWrite1 !== 1)
            $display("FAIL memr_wb: data %h rd %0d wbw %b want 5a5a 5 1", wb_data1, wb_rd1, wb_regWrite1);
        else n_pass++;
        clear_inputs();
        ALU_result_mem = 16'hCAFE; regWrite_mem = 1; Rd_mem = 3'd2;
        step();
        n_total++; if (wb_data1 !== 16'hCAFE || sp1 !== 11'h7FF)
            $display("FAIL passthru: data %h sp %h want cafe 7ff", wb_data1, sp1);
        else n_pass++;
        clear_inputs();
        push_mem = 1; memWrite_mem = 1; memRead_mem = 1; ALU_result_mem = 16'h0020; Rs_data_mem = 16'h4242;
        #1;
        n_total++; if (dmem_addr1 !== 11'h7FF || dmem_we1 !== 1 || dmem_re1 !== 0)
            $display("FAIL priority_port: addr %h we %b re %b want 7ff 1 0", dmem_addr1, dmem_we1, dmem_re1);
        else n_pass++;
        step();
        n_total++; if (sp1 !== 11'h7FE || mem1[11'h7FF] !== 16'h4242)
            $display("FAIL priority_result: sp %h m7ff %h want 7fe 4242", sp1, mem1[11'h7FF]);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_wrap();
        reset_dut();
        n_total++; if (sp2 !== 11'h000 || stall2 !== 0 || {wb_data2, wb_rd2, wb_regWrite2, pc_restore2, pc_restore_valid2, ccr_restore2, ccr_restore_valid2} !== 57'h0)
            $display("FAIL wrap_rst: sp %h stall %b wb %h rd %h wbw %b pc %h pcv %b ccr %h ccrv %b want all 0",
                     sp2, stall2, wb_data2, wb_rd2, wb_regWrite2, pc_restore2, pc_restore_valid2, ccr_restore2, ccr_restore_valid2);
        else n_pass++;
        push_mem = 1; Rs_data_mem = 16'h7777;
        #1;
        n_total++; if (dmem_addr2 !== 11'h000 || dmem_we2 !== 1) $display("FAIL wrap_push_port: addr %h we %b want 000 1", dmem_addr2, dmem_we2); else n_pass++;
        step();
        n_total++; if (sp2 !== 11'h7FF || mem2[0] !== 16'h7777) $display("FAIL wrap_push: sp %h m0 %h want 7ff 7777", sp2, mem2[0]); else n_pass++;
        clear_inputs();
        pop_mem = 1;
        #1;
        n_total++; if (dmem_addr2 !== 11'h000 || dmem_re2 !== 1) $display("FAIL wrap_pop_port: addr %h re %b want 000 1", dmem_addr2, dmem_re2); else n_pass++;
        step();
        n_total++; if (sp2 !== 11'h000 || wb_data2 !== 16'h7777) $display("FAIL wrap_pop: sp %h data %h want 000 7777", sp2, wb_data2); else n_pass++;
        clear_inputs();
        pushPc_mem = 1; pcBeforeInterrupt_mem = 32'hAAAA_BBBB;
        step();
        #1;
        n_total++; if (dmem_addr2 !== 11'h7FF || dmem_wdata2 !== 16'hBBBB) $display("FAIL wrap_pushpc_c2: addr %h wdata %h want 7ff bbbb", dmem_addr2, dmem_wdata2); else n_pass++;
        step();
        n_total++; if (sp2 !== 11'h7FE || mem2[0] !== 16'hAAAA || mem2[11'h7FF] !== 16'hBBBB)
            $display("FAIL wrap_pushpc: sp %h m0 %h m7ff %h want 7fe aaaa bbbb", sp2, mem2[0], mem2[11'h7FF]);
        else n_pass++;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_push_pop();
        test_pushpc_poppc();
        test_ccr();
        test_mem_rw();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller sitting directly downstream of the EX/MEM pipeline register. Consumes the `*_mem` control and data signals, drives the single-port data memory, and owns the stack pointer. Sequences 32-bit PC push/pop as two 16-bit accesses with a one-cycle stall, and produces the registered MEM/WB outputs (write-back data, destination, PC/CCR restore).

## Interface
- `ADDR_W`, 11: data-memory address width; SP is `ADDR_W` bits.
- `SP_RESET`, 2^ADDR_W-1: stack pointer value after reset.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ALU_result_mem` in 16: load/store address (low `ADDR_W` bits used) or pass-through result.
- `Rs_data_mem` in 16: store data and push data.
- `Rd_mem` in 3: destination register.
- `memRead_mem`, `memWrite_mem`, `regWrite_mem`, `push_mem`, `pop_mem` in 1 each: operation controls.
- `pushPc_mem`, `popPc_mem`, `pushCCR_mem`, `popCCR_mem` in 1 each: PC/CCR stack controls.
- `pcBeforeInterrupt_mem` in 32: PC pushed by `pushPc_mem`.
- `ccr_in` in 4: flags pushed by `pushCCR_mem`.
- `dmem_addr` out ADDR_W, `dmem_wdata` out 16, `dmem_we` out 1, `dmem_re` out 1: data-memory port; combinational.
- `dmem_rdata` in 16: asynchronous read data for the current `dmem_addr`.
- `stall` out 1: combinational; upstream holds EX/MEM contents while high.
- `wb_data` out 16, `wb_rd` out 3, `wb_regWrite` out 1: registered MEM/WB outputs.
- `pc_restore` out 32, `pc_restore_valid` out 1: registered; valid pulses one cycle.
- `ccr_restore` out 4, `ccr_restore_valid` out 1: registered; valid pulses one cycle.
- `sp` out ADDR_W: current stack pointer (debug/forwarding).

## Operation
- States: `IDLE`, `PUSHPC2`, `POPPC2`. Reset: state `IDLE`, `sp`=`SP_RESET`, all registered outputs 0; while `rst_n`=0, `dmem_we`/`dmem_re`/`stall` are forced to 0.
- One operation per instruction, priority: `pushPc` > `popPc` > `pushCCR` > `popCCR` > `push` > `pop` > `memWrite` > `memRead`. Lower-priority flags are ignored.
- Stack grows down. Push writes `mem[sp]` and sets `sp`-=1. Pop reads `mem[sp+1]` and sets `sp`+=1. All SP arithmetic is modulo 2^ADDR_W.
- `push`: write `Rs_data_mem`. `pop`: `wb_data`=read value.
- `pushCCR`: write `{12'b0, ccr_in}`. `popCCR`: `ccr_restore`=read[3:0], with `ccr_restore_valid` pulse.
- `memWrite`: `mem[ALU_result_mem]` ← `Rs_data_mem`. `memRead`: `wb_data`=`dmem_rdata`. With no memory op, `wb_data`=`ALU_result_mem`.
- `pushPc`, cycle 1 (`IDLE`):
  - write `pc[31:16]` at `sp`; `stall`=1; go to `PUSHPC2`.
- `pushPc`, cycle 2 (`PUSHPC2`):
  - write `pc[15:0]` at `sp-1`; `stall`=0; `sp`-=2 at the end of this cycle; go to `IDLE`.
- `popPc`, cycle 1 (`IDLE`):
  - read `sp+1` (low half), latch internally; `stall`=1; go to `POPPC2`.
- `popPc`, cycle 2 (`POPPC2`):
  - read `sp+2` (high half); `pc_restore`={high, latched low}; `pc_restore_valid` pulses; `sp`+=2; go to `IDLE`.
- `wb_regWrite` = `regWrite_mem` registered. It is forced to 0 at the edge ending a stalled cycle, so the held instruction retires only once.
- `wb_rd` = `Rd_mem` registered.
- `dmem_re`=1 only in read cycles; `dmem_we`=1 only in write cycles; never both.

## Timing
- Single-cycle ops: memory accessed in the cycle the inputs are presented. `wb_*`, the `*_restore*` outputs and `sp` update at the next rising edge (latency 1).
- PC push/pop: latency 2. `stall` is high for exactly the first cycle; restore outputs and `sp` update at the second edge.
- Back-to-back stack ops: the second op uses the SP updated by the first, with no bubble.
- SP wrap: push at `sp`=0 writes address 0, then `sp`=2^ADDR_W-1. Pop at `sp`=max reads address 0, then `sp`=0.
- `pushPc` at `sp`=0: writes addresses 0 and max, then `sp`=max-1.
- `rst_n` falling mid-sequence aborts the sequence immediately:
  - state `IDLE`, `sp`=`SP_RESET`;
  - no partial `pc_restore_valid` is issued;
  - no further memory writes occur.
- Valid pulses are exactly one cycle wide. Restore outputs hold their value until the next valid.

## Test plan
- Reset: with `rst_n`=0 mid-`PUSHPC2`, `sp`=0x7FF, `stall`=0 and all outputs 0. After release, the first `push` writes to 0x7FF.
- `push` 0xBEEF, then `pop` with Rd=3, regWrite=1:
  - write at 0x7FF, `sp`=0x7FE;
  - read at 0x7FF, `wb_data`=0xBEEF, `wb_rd`=3;
  - `sp`=0x7FF.
- `pushPc` with pc=0x1234_5678, then `popPc`:
  - writes 0x1234@0x7FF and 0x5678@0x7FE; `stall` high for one cycle; `sp`=0x7FD;
  - pop yields `pc_restore`=0x12345678 with a 1-cycle valid pulse; `sp`=0x7FF.
- `pushCCR` ccr=0xA, then `popCCR`: 0x000A stored; `ccr_restore`=0xA with valid pulse; `sp` round-trips.
- `memWrite` 0x5A5A to addr 0x010, then `memRead` addr 0x010 with regWrite: `wb_data`=0x5A5A. A stalled `pushPc` yields exactly one `wb_regWrite` pulse.
- Wrap with `SP_RESET`=0: `push` writes address 0 and `sp`=0x7FF; `pop` reads address 0 and `sp`=0.
